// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, SCL quarter indices and the R/W bit value for the I2C read master
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, READ, MACK, STOP} state_e;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic READ_BIT = 1'b1;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: splits each I2C bit into four quarters of CLK_DIV clocks
//   clk, reset (sync, active-low), en (run; cleared -> counter parked at Q0 start)
//   quarter: current quarter, q_start: first clock of a quarter,
//   sample: last clock of Q1, bit_end: last clock of Q3
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] quarter,
  output logic       q_start,
  output logic       sample,
  output logic       bit_end
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] quarter_q, quarter_d;
  logic last;
  always_comb begin
    last = cnt_q == CW'(CLK_DIV - 1);
    cnt_d = (!en || last) ? '0 : cnt_q + CW'(1);
    quarter_d = !en ? Q0 : last ? quarter_q + 2'd1 : quarter_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      quarter_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      quarter_q <= quarter_d;
    end
  end
  assign quarter = quarter_q;
  assign q_start = en && cnt_q == '0;
  assign sample = en && last && quarter_q == Q1;
  assign bit_end = en && last && quarter_q == Q3;
endmodule

// File: rtl/i2c_read_master.sv
// i2c_read_master: START, 7-bit address + R, read N_BYTES (ACK all but last), STOP
//   clk, reset (sync, active-low), start/address: request, address latched on accept
//   busy, done (1-cycle pulse), nack_err (address not acked), data (byte 0 in MSBs)
//   scl (push-pull), sda_i (pin value), sda_oe (1 = pull SDA low)
module i2c_read_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int N_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             address,
  output logic                   busy,
  output logic                   done,
  output logic                   nack_err,
  output logic [8*N_BYTES-1:0]   data,
  output logic                   scl,
  input  logic                   sda_i,
  output logic                   sda_oe
);
  localparam int W = 8 * N_BYTES;
  state_e state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [W-1:0] shift_q, shift_d, data_q, data_d;
  logic nack_q, nack_d, done_q, done_d;
  logic [1:0] pin_q, pin_d, quarter;
  logic q_start, sample, bit_end, last_byte;
  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q != IDLE),
    .quarter(quarter),
    .q_start(q_start),
    .sample (sample),
    .bit_end(bit_end)
  );
  assign last_byte = byte_q == 3'(N_BYTES - 1);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    bit_d = bit_q;
    byte_d = byte_q;
    shift_d = shift_q;
    data_d = data_q;
    nack_d = nack_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = START;
      addr_d = {address, READ_BIT};
      nack_d = 1'b0;
    end
    if (sample && state_q == ADDR_ACK) nack_d = sda_i;
    if (sample && state_q == READ) shift_d = {shift_q[W-2:0], sda_i};
    if (bit_end) begin
      bit_d = bit_q - 3'd1;
      case (state_q)
        START: begin
          state_d = ADDR;
          bit_d = 3'd7;
        end
        ADDR: state_d = bit_q == 3'd0 ? ADDR_ACK : ADDR;
        ADDR_ACK: begin
          state_d = nack_q ? STOP : READ;
          bit_d = 3'd7;
          byte_d = 3'd0;
        end
        READ: state_d = bit_q == 3'd0 ? MACK : READ;
        MACK: begin
          state_d = last_byte ? STOP : READ;
          bit_d = 3'd7;
          byte_d = byte_q + 3'd1;
        end
        STOP: begin
          state_d = IDLE;
          done_d = 1'b1;
          data_d = nack_q ? data_q : shift_q;
        end
        default: ;
      endcase
    end
  end
  // pin_d is {scl, sda_oe} for the current quarter; START and STOP move SDA at Q2 while SCL is high
  always_comb begin
    pin_d = {quarter == Q1 || quarter == Q2, 1'b0};
    case (state_q)
      START: pin_d = {quarter != Q3, quarter[1]};
      ADDR: pin_d[0] = ~addr_q[bit_q];
      MACK: pin_d[0] = !last_byte;
      STOP: pin_d = {quarter != Q0, !quarter[1]};
      default: ;
    endcase
    {scl, sda_oe} = state_q == IDLE ? 2'b10 : q_start ? pin_d : pin_q;
  end
  // pins are captured on quarter entry and held, so nothing mid-quarter can reach the bus
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
      pin_q <= 2'b10;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      shift_q <= shift_d;
      data_q <= data_d;
      nack_q <= nack_d;
      done_q <= done_d;
      if (q_start) pin_q <= pin_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign nack_err = nack_q;
  assign data = data_q;
endmodule

// File: tb/tb_i2c_read_master.sv
// tb_i2c_read_master: two configurations driven by a bus-level I2C slave model
module tb_i2c_read_master;
  localparam int NBA = 2, CDA = 4, NBB = 1, CDB = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_w [2] = '{1'b0, 1'b0};
  logic [6:0] addr_w [2] = '{7'd0, 7'd0};
  logic sda_i_w [2] = '{1'b1, 1'b1};
  logic scl_w [2], sda_oe_w [2], busy_w [2], done_w [2], nack_w [2];
  logic [15:0] data_a;
  logic [7:0] data_b;
  logic ack_t [2] = '{1'b1, 1'b1};
  logic [7:0] bytes_t [2][2];
  logic [7:0] addr_rx [2], macks [2];
  int rises [2];
  logic stop_seen [2];
  logic [63:0] exp_data [2];
  int vectors = 0, errors = 0;
  i2c_read_master #(.CLK_DIV(CDA), .N_BYTES(NBA)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_w[0]), .address(addr_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .nack_err(nack_w[0]), .data(data_a), .scl(scl_w[0]),
    .sda_i(sda_i_w[0]), .sda_oe(sda_oe_w[0]));
  i2c_read_master #(.CLK_DIV(CDB), .N_BYTES(NBB)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_w[1]), .address(addr_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .nack_err(nack_w[1]), .data(data_b), .scl(scl_w[1]),
    .sda_i(sda_i_w[1]), .sda_oe(sda_oe_w[1]));
  // slave: decodes START/STOP and SCL edges on the wired-AND line, answers on SCL falls
  for (genvar g = 0; g < 2; g++) begin : slv
    localparam int NB = g ? NBB : NBA;
    logic pull = 1'b0, pscl = 1'b1, psda = 1'b1;
    int bitn = 0;
    always @(negedge clk) begin
      logic s, d;
      int j, p;
      s = scl_w[g];
      d = ~sda_oe_w[g] & ~pull;
      j = (bitn - 9) / 9;
      p = (bitn - 9) % 9;
      if (!rst_n) pull = 1'b0;
      else if (pscl && s && psda && !d) begin
        bitn = 0;
        rises[g] = 0;
        stop_seen[g] = 1'b0;
        macks[g] = 8'h00;
      end else if (pscl && s && !psda && d) stop_seen[g] = 1'b1;
      else if (!pscl && s) begin
        if (bitn < 8) addr_rx[g][7-bitn] = d;
        if (bitn > 8 && p == 8 && j < 8) macks[g][j] = d;
        bitn++;
        rises[g] = bitn;
      end else if (pscl && !s)
        pull = bitn == 8 ? ack_t[g] :
               (bitn > 8 && ack_t[g] && j < NB && p < 8) ? ~bytes_t[g][j][7-p] : 1'b0;
      pscl = s;
      psda = ~sda_oe_w[g] & ~pull;
      sda_i_w[g] = psda;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] dat(input int g);
    return g ? 64'(data_b) : 64'(data_a);
  endfunction
  task automatic check_idle(input string tag, input int g);
    check({tag, "_scl"}, 64'(scl_w[g]), 64'd1);
    check({tag, "_sda_oe"}, 64'(sda_oe_w[g]), 64'd0);
    check({tag, "_busy"}, 64'(busy_w[g]), 64'd0);
    check({tag, "_done"}, 64'(done_w[g]), 64'd0);
    check({tag, "_nack"}, 64'(nack_w[g]), 64'd0);
    check({tag, "_data"}, dat(g), 64'd0);
  endtask
  // returns at the falling edge inside the done cycle, so a following call starts in that cycle
  task automatic txn(input int g, input logic [6:0] a, input bit ack, input logic [7:0] b0,
                     input logic [7:0] b1, input bit noise);
    int nb, lat, k;
    nb = g ? NBB : NBA;
    ack_t[g] = ack;
    bytes_t[g][0] = b0;
    bytes_t[g][1] = b1;
    start_w[g] = 1'b1;
    addr_w[g] = a;
    @(negedge clk);
    start_w[g] = 1'b0;
    check("busy_after_start", 64'(busy_w[g]), 64'd1);
    lat = (ack ? 11 + 9 * nb : 11) * 4 * (g ? CDB : CDA);
    k = 0;
    while (!done_w[g] && k < lat + 50) begin
      @(negedge clk);
      k++;
      if (noise) start_w[g] = k == 40;
      if (noise && k == 40) addr_w[g] = ~a;
    end
    check("latency", 64'(k), 64'(lat));
    check("busy_in_done", 64'(busy_w[g]), 64'd0);
    check("nack_err", 64'(nack_w[g]), 64'(!ack));
    check("addr_byte", 64'(addr_rx[g]), 64'({a, 1'b1}));
    check("stop", 64'(stop_seen[g]), 64'd1);
    check("scl_rises", 64'(rises[g]), 64'(ack ? 10 + 9 * nb : 10));
    if (ack) begin
      check("master_acks", 64'(macks[g]), 64'(1) << (nb - 1));
      exp_data[g] = nb == 2 ? 64'({b0, b1}) : 64'(b0);
    end
    check("data", dat(g), exp_data[g]);
  endtask
  initial begin
    int k;
    exp_data = '{64'd0, 64'd0};
    repeat (2) @(negedge clk);
    check_idle("reset_a", 0);
    check_idle("reset_b", 1);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 7'h48, 1'b1, 8'hA4, 8'h55, 1'b0);
    txn(0, 7'h3C, 1'b0, 8'h00, 8'h00, 1'b0);
    txn(0, 7'h21, 1'b1, 8'hC3, 8'h0F, 1'b1);
    txn(0, 7'h50, 1'b1, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(0, 7'($urandom), $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
          $urandom_range(0, 1) == 1);
    end
    ack_t[0] = 1'b1;
    bytes_t[0][0] = 8'($urandom);
    bytes_t[0][1] = 8'($urandom);
    start_w[0] = 1'b1;
    addr_w[0] = 7'h48;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (21 * 16 + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("midreset", 0);
    rst_n = 1'b1;
    exp_data[0] = 64'd0;
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_w[0]) k++;
    end
    check("midreset_no_done", 64'(k), 64'd0);
    txn(1, 7'h48, 1'b1, 8'h7F, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(1, 7'($urandom), $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
          $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
